receiver_failsafe: RTL
======================

// Module: receiver_failsafe
// PURPOSE
// - Arming/failsafe gate between receiver channel values and angle_controller targets.
// - Passes stick values through only while armed and while receiver frames keep arriving.
// - Arming: arm switch on, with throttle at idle, held continuously for ARM_HOLD_US.
// - Link loss: sticks go to centre and throttle is cut or ramped down.
// PARAMETERS
// VAL_W          8       width of every receiver channel value
// CENTER         125     stick-centre value driven on yaw/roll/pitch when not passing through
// ARM_THRESH     200     swa_swb_val >= ARM_THRESH means "arm switch on"
// THROTTLE_IDLE  10      throttle_val <= THROTTLE_IDLE is required to arm
// ARM_HOLD_US    500000  arm condition must hold this many us_clk cycles
// TIMEOUT_US     100000  us_clk cycles with no frame_strobe before FAILSAFE
// RAMP_STEP_US   10000   us_clk cycles per 1-LSB throttle decrement (FAILSAFE_RAMP_EN only)
// PORTS
// us_clk         in   1      1 MHz tick clock; the only clock
// reset          in   1      asynchronous, active-high
// frame_strobe   in   1      1-cycle pulse: receiver has updated all channel values
// throttle_val   in   VAL_W  receiver throttle
// yaw_val        in   VAL_W  receiver yaw
// roll_val       in   VAL_W  receiver roll
// pitch_val      in   VAL_W  receiver pitch
// swa_swb_val    in   VAL_W  arm switch channel
// throttle_out   out  VAL_W  gated throttle to angle_controller
// yaw_out        out  VAL_W  gated yaw
// roll_out       out  VAL_W  gated roll
// pitch_out      out  VAL_W  gated pitch
// armed          out  1      high only in ARMED
// failsafe       out  1      high only in FAILSAFE
// out_strobe     out  1      1-cycle pulse whenever the *_out registers change
// BEHAVIOUR
// - Reset (async, any state): DISARMED. throttle_out=0; yaw/roll/pitch_out=CENTER.
//   armed=0, failsafe=0, out_strobe=0. Both counters cleared.
// - All outputs are registered.
// - Watchdog:
//   - Counter clears on frame_strobe; otherwise +1 per cycle, saturating at TIMEOUT_US.
//   - Saturation while ARMED or ARM_WAIT -> FAILSAFE on the next cycle.
//   - frame_strobe in the same cycle the count would reach TIMEOUT_US: the frame wins, no FAILSAFE.
// - DISARMED: outputs forced to 0/CENTER.
//   - frame_strobe with switch on and throttle idle -> ARM_WAIT, hold counter = 0.
// - ARM_WAIT: outputs still 0/CENTER. Hold counter +1 per cycle.
//   - Any frame_strobe with switch off or throttle > IDLE -> DISARMED.
//   - Hold counter reaching ARM_HOLD_US-1 -> ARMED; armed=1 the following cycle.
// - ARMED: on frame_strobe, the four *_out registers load the inputs 1 cycle later,
//   with out_strobe=1 in that cycle. Between frames, outputs are held.
//   - frame_strobe with switch off -> DISARMED; throttle_out=0 and others=CENTER
//     with out_strobe=1, 1 cycle later.
// - FAILSAFE: failsafe=1, armed=0. yaw/roll/pitch_out=CENTER at entry (out_strobe=1).
//   - Throttle handling depends on FAILSAFE_RAMP_EN (see CONFIGURATION).
//   - Exit to DISARMED only when a frame_strobe arrives with switch off.
//     A frame arriving with switch on keeps FAILSAFE, so re-arming requires toggling the switch.
// - Exactly one state transition per cycle. Counters never wrap; both saturate.
// CONFIGURATION
// - FAILSAFE_RAMP_EN defined: in FAILSAFE, throttle_out decrements by 1 every
//   RAMP_STEP_US cycles, with out_strobe each step. It stops at 0 and never underflows.
// - FAILSAFE_RAMP_EN undefined: throttle_out=0 on the FAILSAFE entry cycle;
//   no ramp counter is synthesised.
// TESTING
// - Reset: assert reset mid-ARMED with throttle_out=180 -> same cycle:
//   throttle_out=0, yaw/roll/pitch_out=125, armed=0.
// - Arm: frames every 20000 cycles, swa=250, thr=5 -> armed=1 after 500000 cycles.
//   Then thr=150 -> throttle_out=150 one cycle after the strobe, with out_strobe.
// - Abort arm: thr=50 frame during ARM_WAIT -> DISARMED, armed stays 0, outputs 0/125.
// - Link loss: ARMED with thr=100, then stop frames -> failsafe=1 at cycle 100001.
//   RAMP_EN: throttle reaches 0 after 100 steps (1,000,000 cycles).
//   No RAMP_EN: throttle_out=0 immediately.
// - Recovery: in FAILSAFE, frame with swa=250 -> stays FAILSAFE.
//   Next frame with swa=0 -> DISARMED, failsafe=0.
// - Race: frame_strobe exactly at watchdog count TIMEOUT_US-1 -> no FAILSAFE, watchdog cleared.

Source files
------------

// File: rtl/receiver_failsafe.sv
// Arming / link-loss gate between receiver channels and angle_controller targets.
// Optional macro FAILSAFE_RAMP_EN: ramp throttle down in FAILSAFE instead of cutting it.
module receiver_failsafe #(
  parameter int VAL_W         = 8,
  parameter int CENTER        = 125,
  parameter int ARM_THRESH    = 200,
  parameter int THROTTLE_IDLE = 10,
  parameter int ARM_HOLD_US   = 500000,
  parameter int TIMEOUT_US    = 100000,
  parameter int RAMP_STEP_US  = 10000
) (
  input  logic             us_clk,
  input  logic             reset,
  input  logic             frame_strobe,
  input  logic [VAL_W-1:0] throttle_val,
  input  logic [VAL_W-1:0] yaw_val,
  input  logic [VAL_W-1:0] roll_val,
  input  logic [VAL_W-1:0] pitch_val,
  input  logic [VAL_W-1:0] swa_swb_val,
  output logic [VAL_W-1:0] throttle_out,
  output logic [VAL_W-1:0] yaw_out,
  output logic [VAL_W-1:0] roll_out,
  output logic [VAL_W-1:0] pitch_out,
  output logic             armed,
  output logic             failsafe,
  output logic             out_strobe
);

  localparam int WD_W   = $clog2(TIMEOUT_US + 1);
  localparam int HOLD_W = $clog2(ARM_HOLD_US + 1);

  localparam logic [VAL_W-1:0]  CENTER_V    = VAL_W'(CENTER);
  localparam logic [VAL_W-1:0]  THRESH_V    = VAL_W'(ARM_THRESH);
  localparam logic [VAL_W-1:0]  IDLE_V      = VAL_W'(THROTTLE_IDLE);
  localparam logic [WD_W-1:0]   WD_MAX      = WD_W'(TIMEOUT_US);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(ARM_HOLD_US - 1);

  typedef enum logic [1:0] {DISARMED, ARM_WAIT, ARMED, FAILSAFE} state_t;

  state_t state, state_next;

  logic [WD_W-1:0]   wd_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [VAL_W-1:0]  thr_next, yaw_next, roll_next, pitch_next;
  logic              strobe_next;
  logic              sw_on, thr_idle, wd_expired, hold_done;

`ifdef FAILSAFE_RAMP_EN
  localparam int RAMP_W = $clog2(RAMP_STEP_US + 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_STEP_US - 1);
  logic [RAMP_W-1:0] ramp_cnt, ramp_next;
`endif

  assign sw_on      = (swa_swb_val >= THRESH_V);
  assign thr_idle   = (throttle_val <= IDLE_V);
  assign wd_expired = (wd_cnt == WD_MAX);
  assign hold_done  = (hold_cnt == HOLD_LAST);

  assign armed    = (state == ARMED);
  assign failsafe = (state == FAILSAFE);

  // Watchdog: a frame in the same cycle it would saturate clears it first.
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset)
      wd_cnt <= '0;
    else if (frame_strobe)
      wd_cnt <= '0;
    else if (!wd_expired)
      wd_cnt <= wd_cnt + WD_W'(1);
  end

  always_ff @(posedge us_clk or posedge reset) begin
    if (reset)
      hold_cnt <= '0;
    else if (state != ARM_WAIT)
      hold_cnt <= '0;
    else if (!hold_done)
      hold_cnt <= hold_cnt + HOLD_W'(1);
  end

  always_comb begin
    state_next  = state;
    thr_next    = throttle_out;
    yaw_next    = yaw_out;
    roll_next   = roll_out;
    pitch_next  = pitch_out;
    strobe_next = 1'b0;
`ifdef FAILSAFE_RAMP_EN
    ramp_next   = ramp_cnt;
`endif
    if ((state == ARM_WAIT || state == ARMED) && wd_expired) begin
      state_next  = FAILSAFE;
      yaw_next    = CENTER_V;
      roll_next   = CENTER_V;
      pitch_next  = CENTER_V;
      strobe_next = 1'b1;
`ifdef FAILSAFE_RAMP_EN
      ramp_next   = '0;
`else
      thr_next    = '0;
`endif
    end else begin
      case (state)
        DISARMED: begin
          if (frame_strobe && sw_on && thr_idle)
            state_next = ARM_WAIT;
        end
        ARM_WAIT: begin
          if (frame_strobe && (!sw_on || !thr_idle))
            state_next = DISARMED;
          else if (hold_done)
            state_next = ARMED;
        end
        ARMED: begin
          if (frame_strobe) begin
            strobe_next = 1'b1;
            if (!sw_on) begin
              state_next = DISARMED;
              thr_next   = '0;
              yaw_next   = CENTER_V;
              roll_next  = CENTER_V;
              pitch_next = CENTER_V;
            end else begin
              thr_next   = throttle_val;
              yaw_next   = yaw_val;
              roll_next  = roll_val;
              pitch_next = pitch_val;
            end
          end
        end
        FAILSAFE: begin
          // Only a switch-off frame leaves; switch-on frames force a toggle first.
          if (frame_strobe && !sw_on) begin
            state_next  = DISARMED;
            thr_next    = '0;
            strobe_next = (throttle_out != '0);
          end
`ifdef FAILSAFE_RAMP_EN
          else if (throttle_out != '0) begin
            if (ramp_cnt == RAMP_LAST) begin
              thr_next    = throttle_out - VAL_W'(1);
              strobe_next = 1'b1;
              ramp_next   = '0;
            end else begin
              ramp_next   = ramp_cnt + RAMP_W'(1);
            end
          end
`endif
        end
        default: state_next = DISARMED;
      endcase
    end
  end

  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      state        <= DISARMED;
      throttle_out <= '0;
      yaw_out      <= CENTER_V;
      roll_out     <= CENTER_V;
      pitch_out    <= CENTER_V;
      out_strobe   <= 1'b0;
    end else begin
      state        <= state_next;
      throttle_out <= thr_next;
      yaw_out      <= yaw_next;
      roll_out     <= roll_next;
      pitch_out    <= pitch_next;
      out_strobe   <= strobe_next;
    end
  end

`ifdef FAILSAFE_RAMP_EN
  always_ff @(posedge us_clk or posedge reset) begin
    if (reset)
      ramp_cnt <= '0;
    else
      ramp_cnt <= ramp_next;
  end
`endif

endmodule
